// File: rtl/fft_out_scheduler_pkg.sv
// Shared types and default geometry for the FFT output scheduler and its mux.
package fft_out_scheduler_pkg;

  localparam int DEF_FRAME_LEN = 42;
  localparam int DEF_OUT_START = 25;
  localparam int DEF_N_POINTS  = 16;
  localparam int DEF_SEL_W     = 4;
  localparam int DEF_CNT_W     = 6;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_CALC = 2'd1,
    FS_OUT  = 2'd2,
    FS_PAD  = 2'd3
  } fs_state_e;

endpackage

// File: rtl/fft_frame_counter.sv
// Frame cycle up-counter with clear (priority), enable and terminal-count flag.
module fft_frame_counter #(
  parameter int CNT_W  = 6,
  parameter int TC_VAL = 41
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt     = cnt_q;
  assign cnt_nxt = cnt_d;
  assign tc      = (cnt_q == CNT_W'(TC_VAL));

endmodule

// File: rtl/fft_out_scheduler.sv
// Frame controller for the 16-point FFT output serializer; all outputs registered.
// Optional output back-pressure (out_ready / hold) is enabled by FFT_SCHED_STALL_EN.
module fft_out_scheduler
  import fft_out_scheduler_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int OUT_START = DEF_OUT_START,
  parameter int N_POINTS  = DEF_N_POINTS,
  parameter int SEL_W     = DEF_SEL_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr_overrun,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy,
  output logic             hold,
  output logic             overrun
);

  if ((FRAME_LEN < OUT_START + N_POINTS) || (OUT_START < 1) ||
      ((1 << SEL_W) < N_POINTS) || ((1 << CNT_W) < FRAME_LEN)) begin : g_bad_params
    $error("fft_out_scheduler: inconsistent FRAME_LEN/OUT_START/N_POINTS/SEL_W/CNT_W");
  end

  localparam logic [CNT_W-1:0] CALC_LAST  = CNT_W'(OUT_START - 1);
  localparam logic [CNT_W-1:0] OUT_LAST   = CNT_W'(OUT_START + N_POINTS - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] OUT_BASE   = CNT_W'(OUT_START);

  fs_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic             stall, eof;

  logic [SEL_W-1:0] sel_q, sel_d;
  logic             sel_valid_q, sel_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic             hold_q, hold_d;
  logic             overrun_q, overrun_d;
  logic             start_q, start_d;

`ifdef FFT_SCHED_STALL_EN
  assign stall = (state_q == FS_OUT) && !out_ready;
`else
  logic unused_out_ready;
  assign unused_out_ready = out_ready;
  assign stall = 1'b0;
`endif

  fft_frame_counter #(
    .CNT_W  (CNT_W),
    .TC_VAL (FRAME_LEN - 1)
  ) u_frame_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .cnt     (cnt_q),
    .cnt_nxt (cnt_d),
    .tc      (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    eof     = 1'b0;
    case (state_q)
      FS_IDLE: if (start) begin
        state_d = FS_CALC;
        cnt_clr = 1'b1;
      end
      FS_CALC: begin
        cnt_en = 1'b1;
        if (cnt_q == CALC_LAST) state_d = FS_OUT;
      end
      FS_OUT: if (!stall) begin
        cnt_en = 1'b1;
        if (cnt_q == OUT_LAST) state_d = FS_PAD;
      end
      FS_PAD:  cnt_en = 1'b1;
      default: state_d = FS_IDLE;
    endcase
    // Frame end overrides the per-state decision; with no pad it lands on the last sample.
    if ((state_q != FS_IDLE) && cnt_tc && !stall) begin
      eof     = 1'b1;
      cnt_clr = 1'b1;
      state_d = start ? FS_CALC : FS_IDLE;
    end
  end

  always_comb begin
    busy_d        = (state_d != FS_IDLE);
    sel_valid_d   = (state_d == FS_OUT);
    sel_d         = sel_valid_d ? SEL_W'(cnt_d - OUT_BASE) : '0;
    frame_start_d = (state_d == FS_CALC) && (cnt_d == '0);
    frame_done_d  = busy_d && (cnt_d == FRAME_LAST) && (cnt_q != FRAME_LAST);
    hold_d        = stall;
    start_d       = start;
    // A request held across the frame is serviced at frame end; only a new request is dropped.
    if (start && !start_q && (state_q != FS_IDLE) && !eof) overrun_d = 1'b1;
    else if (clr_overrun)                                  overrun_d = 1'b0;
    else                                                   overrun_d = overrun_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FS_IDLE;
      sel_q         <= '0;
      sel_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      hold_q        <= 1'b0;
      overrun_q     <= 1'b0;
      start_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      sel_valid_q   <= sel_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
      hold_q        <= hold_d;
      overrun_q     <= overrun_d;
      start_q       <= start_d;
    end
  end

  assign sel         = sel_q;
  assign sel_valid   = sel_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;
  assign hold        = hold_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_fft_out_scheduler.sv
// Directed bench for fft_out_scheduler; expected values come from a per-cycle frame model.
module tb_fft_out_scheduler;

  logic       clk = 1'b0;
  logic       rst_n, start, clr_overrun, out_ready;
  logic [3:0] sel;
  logic       sel_valid, frame_start, frame_done, busy, hold, overrun;
  logic [9:0] obs;
  logic [9:0] expv;

  int n_vec = 0;
  int n_err = 0;

`ifdef FFT_SCHED_STALL_EN
  localparam int STALL_LEN = 3;
`else
  localparam int STALL_LEN = 0;
`endif

  fft_out_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .clr_overrun (clr_overrun),
    .out_ready   (out_ready),
    .sel         (sel),
    .sel_valid   (sel_valid),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .busy        (busy),
    .hold        (hold),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  assign obs = {sel, sel_valid, frame_start, frame_done, busy, hold, overrun};

  // {sel, sel_valid, frame_start, frame_done, busy, hold, overrun} at cycle c after start,
  // with an optional stall of stl cycles beginning at cycle 32 (sel=7).
  function automatic logic [9:0] exp_vec(input int c, input int stl, input bit ov);
    int         e;
    logic       h, v;
    logic [3:0] s;
    e = c;
    h = 1'b0;
    if (stl > 0 && c >= 32 && c <= 32 + stl) begin
      e = 32;
      h = (c > 32);
    end else if (c > 32 + stl) begin
      e = c - stl;
    end
    v = (e >= 25 && e <= 40);
    s = v ? 4'(e - 25) : 4'd0;
    return {s, v, (e == 0), (e == 41), (e <= 41), h, ov};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; clr_overrun = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (obs !== 10'd0) begin
      n_err++;
      $display("FAIL reset_values got %b expected %b", obs, 10'd0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= 42; c++) begin
      if (c > 0) tick();
      expv = exp_vec(c, 0, 1'b0);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL single_frame c=%0d got %b expected %b", c, obs, expv);
      end
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    tick();
    for (int c = 0; c <= 125; c++) begin
      if (c > 0) tick();
      expv = exp_vec(c % 42, 0, 1'b0);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL back_to_back c=%0d got %b expected %b", c, obs, expv);
      end
      if (c == 125) start = 1'b0;
    end
    tick();
    n_vec++;
    if (obs !== 10'd0) begin
      n_err++;
      $display("FAIL back_to_back_idle got %b expected %b", obs, 10'd0);
    end
  endtask

  task automatic test_overrun();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= 42; c++) begin
      if (c > 0) tick();
      expv = exp_vec(c, 0, (c >= 11 && c <= 20));
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL overrun c=%0d got %b expected %b", c, obs, expv);
      end
      start       = (c == 10 || c == 15);
      clr_overrun = (c == 15 || c == 20);
    end
    start = 1'b0;
    clr_overrun = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= 30; c++) begin
      if (c > 0) tick();
      expv = exp_vec(c, 0, 1'b0);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL pre_reset c=%0d got %b expected %b", c, obs, expv);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs !== 10'd0) begin
      n_err++;
      $display("FAIL async_reset got %b expected %b", obs, 10'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++;
      if (obs !== 10'd0) begin
        n_err++;
        $display("FAIL idle_after_reset k=%0d got %b expected %b", k, obs, 10'd0);
      end
    end
  endtask

  task automatic test_stall();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= 42 + STALL_LEN; c++) begin
      if (c > 0) tick();
      expv = exp_vec(c, STALL_LEN, 1'b0);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL stall c=%0d got %b expected %b", c, obs, expv);
      end
      out_ready = !(c >= 32 && c <= 34);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
